// File: rtl/cla_seq_pkg.sv
// Shared types for the multi-precision add/sub controller.
// Holds the FSM state enum, slice width and index-width helper.
package cla_seq_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_w(input int nbytes);
    return (nbytes < 2) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/cla_8b.sv
// 8-bit carry look-ahead adder slice.
// Two 4-bit look-ahead groups with group generate/propagate.
module cla_8b (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       gg0;
  logic       gp0;

  assign g = a & b;
  assign p = a ^ b;

  assign gg0 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
  assign gp0 = &p[3:0];

  always_comb begin
    c    = '0;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = gg0 | (gp0 & cin);
    c[5] = g[4] | (p[4] & c[4]);
    c[6] = g[5] | (p[5] & g[4]) | (p[5] & p[4] & c[4]);
    c[7] = g[6] | (p[6] & g[5]) | (p[6] & p[5] & g[4])
         | (p[6] & p[5] & p[4] & c[4]);
    c[8] = g[7] | (p[7] & g[6]) | (p[7] & p[6] & g[5])
         | (p[7] & p[6] & p[5] & g[4])
         | (p[7] & p[6] & p[5] & p[4] & c[4]);
  end

  assign s    = p ^ c[7:0];
  assign cout = c[8];

endmodule

// File: rtl/cla_seq_adder.sv
// Wide add/sub built by time-multiplexing one cla_8b slice.
// Carry ripples LSB-first through a registered carry flop.
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SLICE_W*NBYTES-1:0] in_a,
  input  logic [SLICE_W*NBYTES-1:0] in_b,
  input  logic                      in_sub,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SLICE_W*NBYTES-1:0] out_sum,
  output logic                      out_cout,
  output logic                      out_ovf,
  output logic                      out_zero,
  output logic                      busy
);

  localparam int W  = SLICE_W * NBYTES;
  localparam int IW = idx_w(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  state_t state;
  state_t state_nx;

  logic [IW-1:0]      idx;
  logic               carry_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       sum_q;
  logic [W-1:0]       res_q;
  logic               cout_q;
  logic               ovf_q;
  logic               zero_q;
  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_s;
  logic               sl_co;
  logic [W-1:0]       sum_nx;
  logic               last;
  logic               ovf_nx;

  assign last = (idx == LAST);

  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx == IW'(i)) begin
        sl_a = a_q[i*SLICE_W +: SLICE_W];
        sl_b = b_q[i*SLICE_W +: SLICE_W];
      end
    end
  end

  cla_8b u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .s    (sl_s),
    .cout (sl_co)
  );

  // Merge the fresh slice into the running sum for this cycle.
  always_comb begin
    sum_nx = sum_q;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx == IW'(i)) begin
        sum_nx[i*SLICE_W +: SLICE_W] = sl_s;
      end
    end
  end

  assign ovf_nx = (a_q[W-1] == b_q[W-1]) && (sl_s[SLICE_W-1] != a_q[W-1]);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        a_q     <= in_a;
        b_q     <= in_sub ? ~in_b : in_b;
        carry_q <= in_sub;
        idx     <= '0;
      end
      if (state == RUN) begin
        sum_q   <= sum_nx;
        carry_q <= sl_co;
        idx     <= last ? '0 : idx + 1'b1;
        // Visible result only moves on the final slice.
        if (last) begin
          res_q  <= sum_nx;
          cout_q <= sl_co;
          ovf_q  <= ovf_nx;
          zero_q <= (sum_nx == '0);
        end
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_sum   = res_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
- Multi-precision add/subtract controller that time-multiplexes one existing 8-bit carry look-ahead adder (cla_8b) over NBYTES byte slices.
- Carry ripples through a registered carry flop, LSB slice first.
- Upstream interface is a valid/ready operand port; downstream interface is a valid/ready result port.
- Lets the datapath do wide (default 32-bit) arithmetic without replicating adder hardware.

Parameters:
- NBYTES, 4, number of 8-bit slices per operation; operand width W = 8*NBYTES; legal range 2..16.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operand request.
- in_ready  output  1  controller can accept operands.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_sub  input  1  0 = A+B, 1 = A-B (B inverted, initial carry 1).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_sum  output  W  result.
- out_cout  output  1  final carry out of the MSB slice (for sub: 1 = no borrow).
- out_ovf  output  1  signed overflow.
- out_zero  output  1  out_sum == 0.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE; slice index, carry, operand and result registers clear to 0.
  - in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0, busy=0.
  - Reset mid-RUN or mid-DONE aborts the operation; the partial result is discarded.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a_q=in_a, b_q = in_sub ? ~in_b : in_b, carry_q=in_sub, idx=0. Go to RUN.
- State RUN:
  - in_ready=0.
  - Each cycle, the cla_8b slice takes A=a_q[8*idx+:8], B=b_q[8*idx+:8], Cin=carry_q.
  - At the edge: sum_q[8*idx+:8]<=S, carry_q<=Cout, idx<=idx+1.
  - When idx==NBYTES-1 at the edge, capture the final flags and go to DONE:
    - out_cout = slice Cout.
    - out_ovf = (a_q[W-1]==b_q[W-1]) && (S[7]!=a_q[W-1]).
    - out_zero = ({S, lower sum_q}==0).
  - Exactly NBYTES RUN cycles per operation; idx never wraps past NBYTES-1.
- State DONE:
  - out_valid=1; out_sum/flags stable and held while out_ready=0 (unbounded backpressure).
  - On out_valid&&out_ready: go to IDLE.
  - out_sum and flags keep their last value after the handshake until the next DONE capture.
  - No new operand is accepted in the DONE cycle; in_ready rises the cycle after the result handshake.
- Latency and throughput:
  - Accept edge at cycle t; out_valid is high during cycle t+NBYTES+1.
  - Peak throughput is one operation per NBYTES+2 cycles.
- Operand stability: in_a/in_b/in_sub are sampled only at the accept edge; later changes have no effect.
- Arithmetic: modulo 2^W. Subtraction is two's complement, A + ~B + 1.
- in_valid while busy is ignored; the upstream holds its request per the valid/ready rule (standard: valid, once high, stays high with stable data until ready).
- X-safety: outputs are never X after the first reset edge.

Decomposition:
- Package cla_seq_pkg: state enum (IDLE, RUN, DONE, 2-bit), function for the slice-index width ($clog2(NBYTES)), localparam SLICE_W=8.
- One sub-module: the existing cla_8b, instantiated once as the shared slice adder. No other sub-modules.
- The controller FSM, index counter, carry flop and result registers live in cla_seq_adder.

Test Plan:
- Reset behaviour: hold rst_n=0 for 2 cycles, then release -> in_ready=1, out_valid=0, out_sum=0, busy=0.
- Basic add: in_a=0x12345678, in_b=0x11111111, add -> after 5 cycles out_sum=0x23456789, cout=0, ovf=0, zero=0.
- Full carry ripple: 0xFFFFFFFF+0x00000001 -> out_sum=0x00000000, cout=1, zero=1, ovf=0. Then 0x7FFFFFFF+0x00000001 -> 0x80000000, ovf=1, cout=0.
- Subtract: 5-7 -> 0xFFFFFFFE, cout=0 (borrow), ovf=0. Then 0x80000000-1 -> 0x7FFFFFFF, ovf=1, cout=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_sum stable, in_ready=0, and a second in_valid is not accepted until 1 cycle after the out handshake.
- Reset mid-operation: pull rst_n=0 at the 2nd RUN cycle -> next cycle IDLE, out_valid=0, out_sum=0. The next operation 1+1 returns 0x00000002 with no stale carry.
